// File: rtl/sump_cmd_decoder_pkg.sv
// Opcode map, FSM state type and output flag bundle for the SUMP command decoder.
package logIP_pkg;

    localparam logic [7:0] OP_RESET     = 8'h00;
    localparam logic [7:0] OP_ARM       = 8'h01;
    localparam logic [7:0] OP_ID        = 8'h02;
    localparam logic [7:0] OP_META      = 8'h04;
    localparam logic [7:0] OP_XON       = 8'h11;
    localparam logic [7:0] OP_XOFF      = 8'h13;
    localparam logic [7:0] OP_DIV       = 8'h80;
    localparam logic [7:0] OP_CNT       = 8'h81;
    localparam logic [7:0] OP_FLGS      = 8'h82;
    localparam logic [7:0] OP_TRIG_BASE = 8'hC0;

    localparam logic [1:0] TRIG_MASK = 2'b00;
    localparam logic [1:0] TRIG_VAL  = 2'b01;
    localparam logic [1:0] TRIG_CFG  = 2'b10;
    localparam logic [1:0] TRIG_RSVD = 2'b11;

    typedef enum logic [0:0] {IDLE, PARAM} cmd_state_t;

    typedef struct packed {
        logic sreset;
        logic arm;
        logic id;
        logic meta;
        logic set_mask;
        logic set_val;
        logic set_cfg;
        logic set_div;
        logic set_cnt;
        logic set_flgs;
        logic exec;
    } flags_t;

    function automatic logic is_trig(input logic [7:0] op);
        return op[7:4] == OP_TRIG_BASE[7:4];
    endfunction

endpackage

// File: rtl/sump_cmd_decoder.sv
// Assembles 1-byte and 5-byte SUMP commands; all strobes are registered one cycle
// after the deciding byte. Partial long commands are dropped after TIMEOUT_CYCLES idle cycles.
module sump_cmd_decoder
    import logIP_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stb_i,
    input  logic [7:0]  data_i,
    output logic [31:0] cmd_o,
    output logic [1:0]  stg_o,
    output logic        set_mask_o,
    output logic        set_val_o,
    output logic        set_cfg_o,
    output logic        set_div_o,
    output logic        set_cnt_o,
    output logic        set_flgs_o,
    output logic        exec_o,
    output logic        arm_o,
    output logic        id_o,
    output logic        meta_o,
    output logic        sreset_o,
    output logic        busy_o
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    cmd_state_t     state_q, state_d;
    logic [1:0]     cnt_q, cnt_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic [7:0]     op_q, op_d;
    logic [23:0]    sh_q, sh_d;
    logic [31:0]    cmd_q, cmd_d;
    logic [1:0]     stg_q, stg_d;
    flags_t         flg_q, flg_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tmo_q   <= '0;
            op_q    <= '0;
            sh_q    <= '0;
            cmd_q   <= '0;
            stg_q   <= '0;
            flg_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            op_q    <= op_d;
            sh_q    <= sh_d;
            cmd_q   <= cmd_d;
            stg_q   <= stg_d;
            flg_q   <= flg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        op_d    = op_q;
        sh_d    = sh_q;
        cmd_d   = cmd_q;
        stg_d   = stg_q;
        flg_d   = '0;

        case (state_q)
            IDLE: begin
                if (stb_i) begin
                    if (data_i[7]) begin
                        op_d    = data_i;
                        cnt_d   = '0;
                        tmo_d   = '0;
                        state_d = PARAM;
                    end else begin
                        case (data_i)
                            OP_RESET:         flg_d.sreset = 1'b1;
                            OP_ARM:           flg_d.arm    = 1'b1;
                            OP_ID:            flg_d.id     = 1'b1;
                            OP_META:          flg_d.meta   = 1'b1;
                            OP_XON, OP_XOFF:  ;
                            default:          ;
                        endcase
                    end
                end
            end
            PARAM: begin
                if (stb_i) begin
                    tmo_d = '0;
                    sh_d  = {data_i, sh_q[23:8]};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = IDLE;
                        if (is_trig(op_q)) begin
                            case (op_q[1:0])
                                TRIG_MASK: flg_d.set_mask = 1'b1;
                                TRIG_VAL:  flg_d.set_val  = 1'b1;
                                TRIG_CFG:  flg_d.set_cfg  = 1'b1;
                                TRIG_RSVD: ;
                                default:   ;
                            endcase
                        end else begin
                            case (op_q)
                                OP_DIV:  flg_d.set_div  = 1'b1;
                                OP_CNT:  flg_d.set_cnt  = 1'b1;
                                OP_FLGS: flg_d.set_flgs = 1'b1;
                                default: ;
                            endcase
                        end
                        // Unknown and reserved opcodes are swallowed without touching cmd/stg.
                        if (flg_d.set_mask || flg_d.set_val || flg_d.set_cfg ||
                            flg_d.set_div || flg_d.set_cnt || flg_d.set_flgs) begin
                            flg_d.exec = 1'b1;
                            cmd_d      = {data_i, sh_q};
                            if (is_trig(op_q)) begin
                                stg_d = op_q[3:2];
                            end
                        end
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_o      = cmd_q;
    assign stg_o      = stg_q;
    assign set_mask_o = flg_q.set_mask;
    assign set_val_o  = flg_q.set_val;
    assign set_cfg_o  = flg_q.set_cfg;
    assign set_div_o  = flg_q.set_div;
    assign set_cnt_o  = flg_q.set_cnt;
    assign set_flgs_o = flg_q.set_flgs;
    assign exec_o     = flg_q.exec;
    assign arm_o      = flg_q.arm;
    assign id_o       = flg_q.id;
    assign meta_o     = flg_q.meta;
    assign sreset_o   = flg_q.sreset;
    assign busy_o     = (state_q == PARAM);

endmodule

// File: tb/tb_sump_cmd_decoder.sv
// Directed bench for sump_cmd_decoder with a short timeout so the discard path is reachable.
module tb_sump_cmd_decoder;

    localparam logic [10:0] F_NONE = 11'h000;
    localparam logic [10:0] F_SRST = 11'h400;
    localparam logic [10:0] F_ARM  = 11'h200;
    localparam logic [10:0] F_ID   = 11'h100;
    localparam logic [10:0] F_META = 11'h080;
    localparam logic [10:0] F_MASK = 11'h040;
    localparam logic [10:0] F_VAL  = 11'h020;
    localparam logic [10:0] F_CFG  = 11'h010;
    localparam logic [10:0] F_DIV  = 11'h008;
    localparam logic [10:0] F_CNT  = 11'h004;
    localparam logic [10:0] F_FLGS = 11'h002;
    localparam logic [10:0] F_EXEC = 11'h001;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        stb_i = 1'b0;
    logic [7:0]  data_i = 8'h00;
    logic [31:0] cmd_o;
    logic [1:0]  stg_o;
    logic        set_mask_o, set_val_o, set_cfg_o, set_div_o, set_cnt_o, set_flgs_o;
    logic        exec_o, arm_o, id_o, meta_o, sreset_o, busy_o;

    int n_chk  = 0;
    int n_pass = 0;
    logic [10:0] sticky;

    sump_cmd_decoder #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .stb_i      (stb_i),
        .data_i     (data_i),
        .cmd_o      (cmd_o),
        .stg_o      (stg_o),
        .set_mask_o (set_mask_o),
        .set_val_o  (set_val_o),
        .set_cfg_o  (set_cfg_o),
        .set_div_o  (set_div_o),
        .set_cnt_o  (set_cnt_o),
        .set_flgs_o (set_flgs_o),
        .exec_o     (exec_o),
        .arm_o      (arm_o),
        .id_o       (id_o),
        .meta_o     (meta_o),
        .sreset_o   (sreset_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [10:0] flags();
        return {sreset_o, arm_o, id_o, meta_o, set_mask_o, set_val_o, set_cfg_o,
                set_div_o, set_cnt_o, set_flgs_o, exec_o};
    endfunction

    // Drive one cycle of input; returns 1ns after the edge that sampled it.
    task automatic drive(input logic s, input logic [7:0] d);
        stb_i  = s;
        data_i = d;
        @(posedge clk_i);
        #1;
        sticky = sticky | flags();
    endtask

    task automatic long_cmd(input logic [7:0] op, input logic [31:0] p);
        drive(1'b1, op);
        drive(1'b1, p[7:0]);
        drive(1'b1, p[15:8]);
        drive(1'b1, p[23:16]);
        drive(1'b1, p[31:24]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        sticky = '0;
        rst_i = 1'b1;
        idle(2);
        rst_i = 1'b0;
        chk("rst_flags", 32'(flags()), 32'(F_NONE));
        chk("rst_cmd",   cmd_o, 32'h0);
        chk("rst_stg",   32'(stg_o), 32'd0);
        chk("rst_busy",  32'(busy_o), 32'd0);

        drive(1'b1, 8'h01);
        chk("arm_pulse", 32'(flags()), 32'(F_ARM));
        drive(1'b0, 8'h00);
        chk("arm_end", 32'(flags()), 32'(F_NONE));
        drive(1'b1, 8'h04);
        chk("meta_pulse", 32'(flags()), 32'(F_META));
        drive(1'b0, 8'h00);

        drive(1'b1, 8'hC4);
        chk("mask_busy_op", 32'(busy_o), 32'd1);
        drive(1'b1, 8'h78);
        drive(1'b1, 8'h56);
        drive(1'b1, 8'h34);
        chk("mask_busy_b2", 32'(busy_o), 32'd1);
        chk("mask_cmd_hold", cmd_o, 32'h0);
        chk("mask_no_flag", 32'(flags()), 32'(F_NONE));
        drive(1'b1, 8'h12);
        chk("mask_flags", 32'(flags()), 32'(F_MASK | F_EXEC));
        chk("mask_cmd", cmd_o, 32'h12345678);
        chk("mask_stg", 32'(stg_o), 32'd1);
        chk("mask_busy_done", 32'(busy_o), 32'd0);
        drive(1'b0, 8'h00);
        chk("mask_end", 32'(flags()), 32'(F_NONE));
        chk("mask_cmd_keep", cmd_o, 32'h12345678);

        long_cmd(8'hCE, 32'h00000001);
        chk("cfg_flags", 32'(flags()), 32'(F_CFG | F_EXEC));
        chk("cfg_cmd", cmd_o, 32'h1);
        chk("cfg_stg", 32'(stg_o), 32'd3);
        long_cmd(8'h80, 32'h0000000A);
        chk("div_flags", 32'(flags()), 32'(F_DIV | F_EXEC));
        chk("div_cmd", cmd_o, 32'hA);
        chk("div_stg", 32'(stg_o), 32'd3);
        long_cmd(8'h81, 32'hDEADBEEF);
        chk("cnt_flags", 32'(flags()), 32'(F_CNT | F_EXEC));
        chk("cnt_cmd", cmd_o, 32'hDEADBEEF);
        long_cmd(8'h82, 32'h00000055);
        chk("flgs_flags", 32'(flags()), 32'(F_FLGS | F_EXEC));
        long_cmd(8'hC9, 32'hCAFEF00D);
        chk("val_flags", 32'(flags()), 32'(F_VAL | F_EXEC));
        chk("val_stg", 32'(stg_o), 32'd2);
        chk("val_cmd", cmd_o, 32'hCAFEF00D);
        drive(1'b0, 8'h00);

        sticky = '0;
        drive(1'b1, 8'hC1);
        drive(1'b1, 8'hAA);
        idle(15);
        chk("tmo_busy_15", 32'(busy_o), 32'd1);
        idle(1);
        chk("tmo_busy_16", 32'(busy_o), 32'd0);
        chk("tmo_no_pulse", 32'(sticky), 32'(F_NONE));
        drive(1'b1, 8'h02);
        chk("tmo_id", 32'(flags()), 32'(F_ID));
        chk("tmo_cmd_keep", cmd_o, 32'hCAFEF00D);
        drive(1'b0, 8'h00);

        drive(1'b1, 8'hC2);
        idle(15);
        drive(1'b1, 8'h11);
        idle(15);
        drive(1'b1, 8'h22);
        idle(15);
        drive(1'b1, 8'h33);
        drive(1'b1, 8'h44);
        chk("tmo_edge_flags", 32'(flags()), 32'(F_CFG | F_EXEC));
        chk("tmo_edge_cmd", cmd_o, 32'h44332211);
        chk("tmo_edge_stg", 32'(stg_o), 32'd0);
        drive(1'b0, 8'h00);

        sticky = '0;
        drive(1'b1, 8'hC0);
        drive(1'b1, 8'h00);
        drive(1'b1, 8'h00);
        rst_i = 1'b1;
        drive(1'b0, 8'h00);
        rst_i = 1'b0;
        chk("rst_mid_busy", 32'(busy_o), 32'd0);
        chk("rst_mid_cmd", cmd_o, 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h00);
            chk($sformatf("sreset_%0d", i), 32'(flags()), 32'(F_SRST));
        end
        drive(1'b0, 8'h00);
        chk("rst_mid_no_exec", 32'(sticky & F_EXEC), 32'(F_NONE));
        chk("rst_mid_cmd_end", cmd_o, 32'h0);

        long_cmd(8'h81, 32'h0BADF00D);
        chk("pre_ign_cmd", cmd_o, 32'h0BADF00D);
        drive(1'b0, 8'h00);
        sticky = '0;
        drive(1'b1, 8'h11);
        drive(1'b1, 8'h13);
        drive(1'b1, 8'h7F);
        drive(1'b1, 8'hC3);
        chk("rsvd_busy", 32'(busy_o), 32'd1);
        drive(1'b1, 8'h78);
        drive(1'b1, 8'h56);
        drive(1'b1, 8'h34);
        drive(1'b1, 8'h12);
        long_cmd(8'h90, 32'h87654321);
        chk("unk_busy_done", 32'(busy_o), 32'd0);
        drive(1'b0, 8'h00);
        chk("ign_no_pulse", 32'(sticky), 32'(F_NONE));
        chk("ign_cmd_keep", cmd_o, 32'h0BADF00D);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
